// File: rtl/mips_div_pkg.sv
// Shared definitions for the execute-stage divider.
// Holds the ALU control encodings that select DIV/DIVU, the divider operand
// width and the divider state encoding. Also has a small decode helper for
// the E stage that turns alucontrolE into the divider start request.
package mips_div_pkg;

  localparam int unsigned DIV_WIDTH  = 32;
  localparam int unsigned ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] DIV_CONTROL  = 5'b11010;
  localparam logic [ALU_CTRL_W-1:0] DIVU_CONTROL = 5'b11011;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_BUSY   = 2'b10,
    DIV_DONE   = 2'b11
  } divState_t;

  // True when the E-stage ALU control selects either divide flavour.
  function automatic logic isDivOp(input logic [ALU_CTRL_W-1:0] aluControl);
    return (aluControl == DIV_CONTROL) || (aluControl == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor at WIDTH+1 bits and restores on a borrow.
// Ports:
//   remIn        current partial remainder (always < divisor for nonzero divisor)
//   dividendMsb  dividend bit being shifted into the remainder
//   divisor      divisor magnitude
//   remNext_c    partial remainder after this iteration
//   quoBit_c     quotient bit produced by this iteration
module div_step
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendMsb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext_c,
  output logic             quoBit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Because remIn < divisor, the shifted value is < 2*divisor, so bit WIDTH of
  // the difference is a reliable borrow flag.
  always_comb begin
    shifted   = {remIn, dividendMsb};
    diff      = shifted - {1'b0, divisor};
    quoBit_c  = ~diff[WIDTH];
    remNext_c = quoBit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_div.sv
// Multi-cycle DIV/DIVU unit for the execute stage of the 5-stage MIPS pipeline.
// Radix-2 restoring divider, one quotient bit per cycle, with sign
// pre-processing (operand magnitudes) and post-processing (quotient/remainder
// sign fix-up). ready_o feeds the hazard unit; F/D/E stall while a divide is
// in E and ready_o is low.
// Optional feature: define DIV_BYZERO_FAST_EN to short-circuit a zero
// divisor into a 2-cycle {dividend, all-ones} result. Without it a zero
// divisor runs the full iteration sequence.
// Ports:
//   clk           pipeline clock
//   resetn        asynchronous active-low reset
//   start_i       a DIV/DIVU is in E
//   signed_div_i  1 = DIV, 0 = DIVU
//   opdata1_i     dividend (rs)
//   opdata2_i     divisor (rt)
//   annul_i       cancel the operation in flight
//   result_o      {remainder, quotient}, written to {HI, LO}
//   ready_o       one-cycle pulse, result_o valid
module mips_div
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  divState_t state;
  divState_t stateNext;

  logic [CNT_W-1:0]   iterCnt;
  logic [CNT_W-1:0]   iterCntNext;
  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   remNext;
  // Holds the dividend magnitude; quotient bits shift in from the bottom as
  // dividend bits leave from the top.
  logic [WIDTH-1:0]   quoReg;
  logic [WIDTH-1:0]   quoNext;
  logic [WIDTH-1:0]   divisorReg;
  logic [WIDTH-1:0]   divisorNext;
  logic               negQuo;
  logic               negQuoNext;
  logic               negRem;
  logic               negRemNext;
  logic [2*WIDTH-1:0] resultNext;
  logic               readyNext;

  logic               dividendNeg;
  logic               divisorNeg;
  logic [WIDTH-1:0]   dividendMag;
  logic [WIDTH-1:0]   divisorMag;
`ifdef DIV_BYZERO_FAST_EN
  logic               divisorZero;
`endif

  logic [WIDTH-1:0]   stepRem;
  logic               stepBit;
  logic [WIDTH-1:0]   quoShifted;
  logic [WIDTH-1:0]   quoFinal;
  logic [WIDTH-1:0]   remFinal;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // exactly the unsigned magnitude we need.
  always_comb begin : operandPrep
    dividendNeg = signed_div_i & opdata1_i[WIDTH-1];
    divisorNeg  = signed_div_i & opdata2_i[WIDTH-1];
    dividendMag = dividendNeg ? -opdata1_i : opdata1_i;
    divisorMag  = divisorNeg  ? -opdata2_i : opdata2_i;
`ifdef DIV_BYZERO_FAST_EN
    divisorZero = (opdata2_i == '0);
`endif
  end

  div_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .remIn      (remReg),
    .dividendMsb(quoReg[WIDTH-1]),
    .divisor    (divisorReg),
    .remNext_c  (stepRem),
    .quoBit_c   (stepBit)
  );

  // Final-iteration values with the sign fix-up applied.
  always_comb begin : signFix
    quoShifted = {quoReg[WIDTH-2:0], stepBit};
    quoFinal   = negQuo ? -quoShifted : quoShifted;
    remFinal   = negRem ? -stepRem    : stepRem;
  end

  // Next-state and datapath control.
  always_comb begin : fsmNext
    stateNext   = state;
    iterCntNext = iterCnt;
    remNext     = remReg;
    quoNext     = quoReg;
    divisorNext = divisorReg;
    negQuoNext  = negQuo;
    negRemNext  = negRem;
    resultNext  = result_o;
    readyNext   = 1'b0;

    unique case (state)
      DIV_IDLE: begin
        // Annul wins over a simultaneous start.
        if (!annul_i && start_i) begin
          iterCntNext = '0;
          remNext     = '0;
          divisorNext = divisorMag;
          negQuoNext  = dividendNeg ^ divisorNeg;
          negRemNext  = dividendNeg;
`ifdef DIV_BYZERO_FAST_EN
          // The fast path reports the raw dividend, so keep it unmodified.
          if (divisorZero) begin
            stateNext = DIV_BYZERO;
            quoNext   = opdata1_i;
          end else begin
            stateNext = DIV_BUSY;
            quoNext   = dividendMag;
          end
`else
          stateNext = DIV_BUSY;
          quoNext   = dividendMag;
`endif
        end
      end

`ifdef DIV_BYZERO_FAST_EN
      DIV_BYZERO: begin
        if (annul_i) begin
          stateNext = DIV_IDLE;
        end else begin
          stateNext  = DIV_DONE;
          readyNext  = 1'b1;
          resultNext = {quoReg, {WIDTH{1'b1}}};
        end
      end
`endif

      DIV_BUSY: begin
        if (annul_i) begin
          stateNext = DIV_IDLE;
        end else begin
          remNext     = stepRem;
          quoNext     = quoShifted;
          iterCntNext = iterCnt + CNT_W'(1);
          if (iterCnt == LAST_ITER) begin
            stateNext   = DIV_DONE;
            iterCntNext = '0;
            readyNext   = 1'b1;
            resultNext  = {remFinal, quoFinal};
          end
        end
      end

      // DONE lasts one cycle regardless of annul; the pipeline drops the result.
      DIV_DONE: stateNext = DIV_IDLE;

      default: stateNext = DIV_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= DIV_IDLE;
      iterCnt    <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      state      <= stateNext;
      iterCnt    <= iterCntNext;
      remReg     <= remNext;
      quoReg     <= quoNext;
      divisorReg <= divisorNext;
      negQuo     <= negQuoNext;
      negRem     <= negRemNext;
      result_o   <= resultNext;
      ready_o    <= readyNext;
    end
  end

endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div. A transaction-level model predicts, from
// the inputs alone, when ready_o must pulse and what result_o must hold; a
// compare process checks the DUT against it every cycle. Literal expectations
// on selected vectors pin both the model and the DUT.
// Honours DIV_BYZERO_FAST_EN the same way the design does.
module tb_mips_div;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_i;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;
  int litCyc = -1;
  logic [2*W-1:0] litExp = '0;

  mips_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start_i),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latency(input logic [W-1:0] b);
`ifdef DIV_BYZERO_FAST_EN
    if (b == '0) return 2;
`endif
    return W + 1;
  endfunction

  // Architectural result: truncating division, remainder takes dividend sign.
  function automatic logic [2*W-1:0] refDiv(input bit sgn, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int qs;
    int rs;
    logic [W-1:0] magA;
    if (b == '0) begin
`ifdef DIV_BYZERO_FAST_EN
      return {a, 32'hFFFF_FFFF};
`else
      if (!sgn || !a[W-1]) return {a, 32'hFFFF_FFFF};
      // Negative dividend: magnitude quotient all-ones negated, remainder re-signed.
      magA = -a;
      return {-magA, 32'h0000_0001};
`endif
    end
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    qs = $signed(a) / $signed(b);
    rs = $signed(a) % $signed(b);
    return {rs[W-1:0], qs[W-1:0]};
  endfunction

  // Transaction model: an accepted start produces one ready pulse after the
  // architectural latency unless annulled first; DONE blocks a start for one cycle.
  logic           mReady;
  logic [2*W-1:0] mRes;
  logic [2*W-1:0] pendRes;
  bit             pendActive;
  int             doneCyc;
  int             idleAt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mReady     <= 1'b0;
      mRes       <= '0;
      pendActive <= 1'b0;
      idleAt     <= 0;
    end else begin
      mReady <= 1'b0;
      if (pendActive) begin
        if (annul_i) begin
          pendActive <= 1'b0;
          idleAt     <= cyc + 1;
        end else if (cyc == doneCyc - 1) begin
          pendActive <= 1'b0;
          mReady     <= 1'b1;
          mRes       <= pendRes;
          idleAt     <= cyc + 2;
        end
      end else if (cyc >= idleAt && start_i && !annul_i) begin
        pendActive <= 1'b1;
        doneCyc    <= cyc + latency(opdata2_i);
        pendRes    <= refDiv(signed_div_i, opdata1_i, opdata2_i);
      end
    end
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      chk("ready_o", 64'(ready_o), 64'(mReady));
      chk("result_o", result_o, mRes);
      if (cyc == litCyc) begin
        chk("lit_ready", 64'(ready_o), 64'd1);
        chk("lit_result", result_o, litExp);
        chk("lit_model", mRes, litExp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one divide at the current cycle; returns once the unit is idle again.
  task automatic runDiv(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit useLit, input logic [2*W-1:0] lit, input bit annulDone);
    int t;
    int lat;
    t = cyc;
    lat = latency(b);
    start_i = 1'b1;
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    if (useLit) begin
      litExp = lit;
      litCyc = t + lat;
    end
    tick(1);
    start_i = 1'b0;
    signed_div_i = 1'($urandom);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    tick(lat - 1);
    if (annulDone) annul_i = 1'b1;
    tick(1);
    annul_i = 1'b0;
  endtask

  initial begin
    int t;
    resetn = 1'b1;
    start_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i = 1'b0;
    #1;
    resetn = 1'b0;
    checkEn = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(2);

    runDiv(1'b0, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, 1'b0);
    runDiv(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
    runDiv(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 64'h00000002_FFFFFFF2, 1'b0);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 1'b0);
    runDiv(1'b0, 32'h0000_1234, 32'h0, 1'b1, 64'h00001234_FFFFFFFF, 1'b0);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 64'h00000000_FFFFFFFF, 1'b1);
    runDiv(1'b0, 32'd5, 32'd10, 1'b1, 64'h00000005_00000000, 1'b0);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 64'hFFFFFFFF_00000003, 1'b0);
    runDiv(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'h7FFFFFFF_00000000, 1'b0);
    runDiv(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, '0, 1'b0);
    runDiv(1'b1, 32'hFFFF_FFFB, 32'h0, 1'b0, '0, 1'b0);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);

    // Annul together with start in IDLE: nothing may start.
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd99;
    opdata2_i = 32'd9;
    tick(1);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick(40);

    // Annul mid-operation, then a fresh divide two cycles later.
    t = cyc;
    start_i = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'h0000_FFFF;
    opdata2_i = 32'h0000_0010;
    tick(1);
    start_i = 1'b0;
    tick(9);
    annul_i = 1'b1;
    tick(1);
    annul_i = 1'b0;
    tick(1);
    if (cyc != t + 12) $display("note: annul sequence offset %0d", cyc - t);
    runDiv(1'b0, 32'd1000, 32'd3, 1'b1, 64'h00000001_0000014D, 1'b0);

    // Reset in the middle of a divide discards everything.
    start_i = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'd123;
    opdata2_i = 32'd4;
    tick(1);
    start_i = 1'b0;
    tick(4);
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(40);

    // Back-to-back with start held high across the DONE cycle.
    t = cyc;
    start_i = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    litExp = 64'h00000000_0000000A;
    litCyc = t + 33;
    tick(1);
    opdata1_i = 32'd77;
    opdata2_i = 32'd8;
    tick(33);
    litExp = 64'h00000005_00000009;
    litCyc = t + 67;
    tick(1);
    start_i = 1'b0;
    tick(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_div.md
# mips_div

Multi-cycle 32-bit integer divider in the execute stage of the 5-stage MIPS pipeline. It executes DIV/DIVU and produces the {HI, LO} pair. Its `ready_o` drives the hazard unit's `ready_oE`. While a divide is in E and `ready_o` is low, the hazard unit stalls F/D/E. The block is a radix-2 restoring divider with one quotient bit per cycle, plus sign pre- and post-processing.

## Interface
Parameters:
- `WIDTH`, 32, operand width. The result is `2*WIDTH` bits.

Ports:
- `clk`  in  1  pipeline clock. All state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  a DIV/DIVU is in E. Driven high when `alucontrolE` is DIV_CONTROL or DIVU_CONTROL.
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend (rs, after E forwarding).
- `opdata2_i`  in  WIDTH  divisor (rt, after E forwarding).
- `annul_i`  in  1  cancel the operation in flight (flush or exception).
- `result_o`  out  2*WIDTH  {remainder, quotient}. Written to {HI, LO}.
- `ready_o`  out  1  result valid this cycle.

## Operation
- States: IDLE, BYZERO, BUSY, DONE.
- IDLE
  - `annul_i`=1 → stay in IDLE. Annul has priority over start.
  - else `start_i`=1 → latch operands and `signed_div_i`.
  - divisor 0 → go to BYZERO; otherwise go to BUSY.
  - On entry to BUSY: load `|dividend|` and `|divisor|` (magnitudes when signed), iteration counter = 0, partial remainder = 0.
- BUSY
  - Each cycle: shift {partial remainder, dividend} left 1 and trial-subtract the divisor at WIDTH+1 bits.
  - Non-negative → keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments. After the iteration with counter = WIDTH-1, go to DONE.
  - `annul_i`=1 → go to IDLE next cycle. No result is written and `ready_o` does not assert.
- BYZERO (present only with DIV_BYZERO_FAST_EN)
  - Result = {dividend raw, 0xFFFFFFFF}.
  - Go to DONE, unless `annul_i`, in which case go to IDLE.
- Sign fix-up, applied when registering `result_o` on entry to DONE, signed case only:
  - Negate the quotient if the operand signs differ.
  - Give the remainder the sign of the dividend.
- Overflow: 0x80000000 / 0xFFFFFFFF signed → q = 0x80000000, r = 0. This falls out of the two's-complement magnitudes; no special case.
- DONE: `ready_o`=1 for exactly one cycle, then go to IDLE unconditionally.
- A `start_i` still high in IDLE after DONE belongs to the next instruction, because the hazard unit released the stall. Back-to-back divides are supported this way.
- Operand inputs are ignored outside IDLE.

## Timing
- Reset: state IDLE, `ready_o`=0, `result_o`=0, counter 0. Reset mid-operation discards all work.
- Latency counts from the cycle T in which IDLE samples `start_i`:
  - normal: BUSY during T+1..T+WIDTH, `ready_o`=1 at T+WIDTH+1 (T+33).
  - zero divisor with the fast path: `ready_o`=1 at T+2.
- `ready_o` and `result_o` are registered. `result_o` holds its last value until the next DONE.
- `annul_i` takes effect at the next edge. If `annul_i` and DONE coincide, DONE still completes. The pipeline discards the result.

## Configuration
- `DIV_BYZERO_FAST_EN`
  - Defined: zero divisor takes the BYZERO path; 2-cycle result {dividend, 0xFFFFFFFF}.
  - Undefined: BYZERO state and decode removed. A zero divisor runs the full 32 iterations, and the result is whatever the datapath produces:
    - unsigned: q = 0xFFFFFFFF, r = dividend (identical to the fast path).
    - signed: the magnitude result after sign fix-up.

## Structure
- Shared defines header holds `DIV_CONTROL`/`DIVU_CONTROL` (already used by the E stage), the state encodings, and `DIV_WIDTH`.
- One sub-module: `div_step`, a combinational single-iteration shift/trial-subtract producing {next remainder, quotient bit}. `mips_div` owns the FSM, counter, registers and sign logic.

## Test plan
- DIVU 100 / 7, start at T → `ready_o`=1 only at T+33; result {0x00000002, 0x0000000E}.
- DIV -100 / 7 → q = 0xFFFFFFF2, r = 0xFFFFFFFE. DIV 100 / -7 → q = 0xFFFFFFF2, r = 0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}, no hang.
- DIVU 0x1234 / 0:
  - macro defined → ready at T+2, {0x00001234, 0xFFFFFFFF}.
  - macro undefined → ready at T+33, same value.
- `annul_i` at T+10 → IDLE at T+11, `ready_o` never asserts, `result_o` unchanged. A new start at T+12 completes at T+45. Separately, `resetn` low at T+5 → outputs 0 immediately.
- Two DIVU back-to-back with `start_i` held high → two `ready_o` pulses at T+33 and T+67, each with the correct result.
